// File: rtl/mig_pkg.sv
// Shared types and constants for the sequential MIG evaluator.
package mig_pkg;

  // Widest node index for NUM_PI<=8 and MAX_GATES<=64 (73 nodes).
  localparam int MAX_IDX_W    = 7;
  localparam int NODE_CONST0  = 0;
  localparam int NODE_PI_BASE = 1;

  typedef struct packed {
    logic                 compl;
    logic [MAX_IDX_W-1:0] index;
  } operand_t;

  typedef struct packed {
    operand_t c;
    operand_t b;
    operand_t a;
  } gate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int num_pi, input int max_gates);
    return $clog2(1 + num_pi + max_gates);
  endfunction

endpackage

// File: rtl/mig_maj_unit.sv
// Bitwise three-input majority with per-operand complement, shared by all gates.
module mig_maj_unit #(
  parameter int LANES = 16
) (
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic [LANES-1:0] c,
  input  logic             ca,
  input  logic             cb,
  input  logic             cc,
  output logic [LANES-1:0] y
);

  logic [LANES-1:0] a_s, b_s, c_s;

  // complement operands, then majority per lane
  always_comb begin
    a_s = a ^ {LANES{ca}};
    b_s = b ^ {LANES{cb}};
    c_s = c ^ {LANES{cc}};
    y   = (a_s & b_s) | (a_s & c_s) | (b_s & c_s);
  end

endmodule

// File: rtl/mig_seq_eval.sv
// Programmable MIG netlist evaluated one gate per cycle, LANES input vectors in parallel.
module mig_seq_eval
  import mig_pkg::*;
#(
  parameter  int NUM_PI    = 4,
  parameter  int MAX_GATES = 16,
  parameter  int LANES     = 16,
  localparam int IDX_W     = idx_w(NUM_PI, MAX_GATES),
  localparam int OP_W      = IDX_W + 1,
  localparam int ADDR_W    = (MAX_GATES > 1) ? $clog2(MAX_GATES) : 1,
  localparam int CNT_W     = $clog2(MAX_GATES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prog_we,
  input  logic [ADDR_W-1:0]       prog_addr,
  input  logic [3*OP_W-1:0]       prog_data,
  input  logic                    cfg_we,
  input  logic [CNT_W-1:0]        cfg_num_gates,
  input  logic [OP_W-1:0]         cfg_out,
  output logic                    prog_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_PI*LANES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_data
);

  state_t                  state_r, state_nxt_s;
  gate_t                   gate_mem_r [MAX_GATES];
  logic [LANES-1:0]        node_r [MAX_GATES];
  logic [NUM_PI*LANES-1:0] in_data_r;
  logic [CNT_W-1:0]        num_gates_r, g_r;
  operand_t                cfg_out_r;
  logic                    in_ready_r, out_valid_r, prog_err_r;
  logic [LANES-1:0]        out_data_r;

  logic                    idle_s, accept_s, last_gate_s, load_out_s;
  logic [CNT_W-1:0]        num_gates_clamp_s, num_gates_eff_s;
  operand_t                cfg_out_in_s, cfg_out_eff_s;
  gate_t                   gate_in_s, gate_cur_s;
  logic [LANES-1:0]        opa_s, opb_s, opc_s, maj_s, sel_val_s, out_data_nxt_s;

  function automatic operand_t to_operand(input logic [OP_W-1:0] f);
    operand_t o;
    o.compl = f[IDX_W];
    o.index = MAX_IDX_W'(f[IDX_W-1:0]);
    return o;
  endfunction

  // Out-of-range indices and (with use_nodes low) gate nodes read as zero.
  function automatic logic [LANES-1:0] read_node(
    input logic [MAX_IDX_W-1:0]    idx,
    input logic [NUM_PI*LANES-1:0] pis,
    input logic [LANES-1:0]        nodes [MAX_GATES],
    input logic                    use_nodes
  );
    int unsigned      i;
    logic [LANES-1:0] val;
    i   = 32'(idx);
    val = {LANES{1'b0}};
    for (int k = 0; k < NUM_PI; k++) begin
      val = (i == 32'(NODE_PI_BASE + k)) ? pis[k*LANES +: LANES] : val;
    end
    for (int k = 0; k < MAX_GATES; k++) begin
      val = (use_nodes && (i == 32'(NODE_PI_BASE + NUM_PI + k))) ? nodes[k] : val;
    end
    val = (i == 32'(NODE_CONST0)) ? {LANES{1'b0}} : val;
    return val;
  endfunction

  // decode incoming program/config words; a same-cycle config write wins over the stored one
  always_comb begin
    idle_s            = (state_r == IDLE);
    gate_in_s.a       = to_operand(prog_data[0*OP_W +: OP_W]);
    gate_in_s.b       = to_operand(prog_data[1*OP_W +: OP_W]);
    gate_in_s.c       = to_operand(prog_data[2*OP_W +: OP_W]);
    cfg_out_in_s      = to_operand(cfg_out);
    num_gates_clamp_s = (cfg_num_gates > CNT_W'(MAX_GATES)) ? CNT_W'(MAX_GATES) : cfg_num_gates;
    if (cfg_we && idle_s) begin
      num_gates_eff_s = num_gates_clamp_s;
      cfg_out_eff_s   = cfg_out_in_s;
    end else begin
      num_gates_eff_s = num_gates_r;
      cfg_out_eff_s   = cfg_out_r;
    end
    accept_s    = idle_s && in_valid && in_ready_r;
    last_gate_s = ((g_r + CNT_W'(1)) == num_gates_r);
  end

  // fetch current gate word and its operand values
  always_comb begin
    gate_cur_s = gate_mem_r[g_r[ADDR_W-1:0]];
    opa_s      = read_node(gate_cur_s.a.index, in_data_r, node_r, 1'b1);
    opb_s      = read_node(gate_cur_s.b.index, in_data_r, node_r, 1'b1);
    opc_s      = read_node(gate_cur_s.c.index, in_data_r, node_r, 1'b1);
  end

  mig_maj_unit #(.LANES(LANES)) u_maj (
    .a  (opa_s),
    .b  (opb_s),
    .c  (opc_s),
    .ca (gate_cur_s.a.compl),
    .cb (gate_cur_s.b.compl),
    .cc (gate_cur_s.c.compl),
    .y  (maj_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = (num_gates_eff_s == CNT_W'(0)) ? DONE : EVAL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EVAL: begin
        if (last_gate_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = EVAL;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: result value captured on entry to DONE, last gate bypassed from the MAJ unit
  always_comb begin
    sel_val_s = {LANES{1'b0}};
    case (state_r)
      IDLE: sel_val_s = read_node(cfg_out_eff_s.index, in_data, node_r, 1'b0);
      EVAL: begin
        if (32'(cfg_out_r.index) == 32'(NUM_PI + 1) + 32'(g_r)) begin
          sel_val_s = maj_s;
        end else begin
          sel_val_s = read_node(cfg_out_r.index, in_data_r, node_r, 1'b1);
        end
      end
      default: sel_val_s = read_node(cfg_out_r.index, in_data_r, node_r, 1'b1);
    endcase
    out_data_nxt_s = sel_val_s ^ {LANES{(state_r == IDLE) ? cfg_out_eff_s.compl : cfg_out_r.compl}};
    load_out_s     = (state_nxt_s == DONE) && (state_r != DONE);
  end

  // program and configuration store, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAX_GATES; k++) begin
        gate_mem_r[k] <= '0;
      end
      num_gates_r <= CNT_W'(0);
      cfg_out_r   <= '0;
    end else begin
      if (prog_we && idle_s && (32'(prog_addr) < 32'(MAX_GATES))) begin
        gate_mem_r[prog_addr] <= gate_in_s;
      end
      if (cfg_we && idle_s) begin
        num_gates_r <= num_gates_clamp_s;
        cfg_out_r   <= cfg_out_in_s;
      end
    end
  end

  // evaluation datapath: input latch, gate counter, node values
  always_ff @(posedge clk) begin
    if (rst) begin
      in_data_r <= {(NUM_PI*LANES){1'b0}};
      g_r       <= CNT_W'(0);
      for (int k = 0; k < MAX_GATES; k++) begin
        node_r[k] <= {LANES{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            in_data_r <= in_data;
            g_r       <= CNT_W'(0);
            for (int k = 0; k < MAX_GATES; k++) begin
              node_r[k] <= {LANES{1'b0}};
            end
          end
        end
        EVAL: begin
          node_r[g_r[ADDR_W-1:0]] <= maj_s;
          g_r                     <= g_r + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // registered handshake, result and error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {LANES{1'b0}};
      prog_err_r  <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      prog_err_r  <= (prog_we || cfg_we) && !idle_s;
      if (load_out_s) begin
        out_data_r <= out_data_nxt_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign prog_err  = prog_err_r;

endmodule

// File: tb/tb_mig_seq_eval.sv
// Directed, table-driven bench for mig_seq_eval (NUM_PI=4, MAX_GATES=16, LANES=16).
module tb_mig_seq_eval;

  localparam logic [63:0] IN_VEC = 64'hFF00_F0F0_CCCC_AAAA;

  logic        clk = 1'b0;
  logic        rst, prog_we, cfg_we, in_valid, out_ready;
  logic [3:0]  prog_addr;
  logic [17:0] prog_data;
  logic [4:0]  cfg_num_gates;
  logic [5:0]  cfg_out;
  logic [63:0] in_data;
  logic        prog_err, in_ready, out_valid;
  logic [15:0] out_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [17:0] g0;
    logic [17:0] g1;
    logic [4:0]  ng;
    logic [5:0]  osel;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  mig_seq_eval #(.NUM_PI(4), .MAX_GATES(16), .LANES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .cfg_we        (cfg_we),
    .cfg_num_gates (cfg_num_gates),
    .cfg_out       (cfg_out),
    .prog_err      (prog_err),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] op(input logic c, input int idx);
    logic [4:0] ix;
    ix = 5'(idx);
    return {c, ix};
  endfunction

  function automatic logic [17:0] gw(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    return {c, b, a};
  endfunction

  function automatic vec_t mk(input string n, input logic [17:0] g0, input logic [17:0] g1,
                              input logic [4:0] ng, input logic [5:0] os,
                              input logic [15:0] e, input int l);
    vec_t v;
    v.name = n; v.g0 = g0; v.g1 = g1; v.ng = ng; v.osel = os; v.exp_data = e; v.exp_lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [3:0] addr, input logic [17:0] data);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    step();
    prog_we = 1'b0;
  endtask

  task automatic cfg(input logic [4:0] ng, input logic [5:0] os);
    cfg_we = 1'b1; cfg_num_gates = ng; cfg_out = os;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: in_ready still %b after %0d cycles", in_ready, n);
    end
  endtask

  // accept one run (optionally with same-cycle writes) and collect result latency/data
  task automatic run(input logic wp, input logic [17:0] pd, input logic wc,
                     input logic [4:0] ng, input logic [5:0] os,
                     output int lat, output logic [15:0] data);
    wait_ready();
    in_valid = 1'b1; in_data = IN_VEC;
    prog_we = wp; prog_addr = 4'd0; prog_data = pd;
    cfg_we = wc; cfg_num_gates = ng; cfg_out = os;
    step();
    in_valid = 1'b0; prog_we = 1'b0; cfg_we = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    data = out_data;
    step();
  endtask

  initial begin
    logic [17:0] maj3_g, and_g, or_g, chain_g1, x3_g;
    int          lat;
    logic [15:0] data;
    logic        seen;

    maj3_g   = gw(op(1'b0, 1), op(1'b0, 2), op(1'b0, 3));
    and_g    = gw(op(1'b0, 1), op(1'b0, 2), op(1'b0, 0));
    or_g     = gw(op(1'b0, 1), op(1'b0, 2), op(1'b1, 0));
    chain_g1 = gw(op(1'b0, 5), op(1'b0, 3), op(1'b1, 0));
    x3_g     = gw(op(1'b0, 4), op(1'b0, 4), op(1'b0, 4));

    vecs[0]  = mk("maj3",      maj3_g, 18'd0,    5'd1, op(1'b0, 5), 16'hE8E8, 2);
    vecs[1]  = mk("maj3_inv",  maj3_g, 18'd0,    5'd1, op(1'b1, 5), 16'h1717, 2);
    vecs[2]  = mk("and",       and_g,  18'd0,    5'd1, op(1'b0, 5), 16'h8888, 2);
    vecs[3]  = mk("or",        or_g,   18'd0,    5'd1, op(1'b0, 5), 16'hEEEE, 2);
    vecs[4]  = mk("chain",     and_g,  chain_g1, 5'd2, op(1'b0, 6), 16'hF8F8, 3);
    vecs[5]  = mk("g0_pi",     maj3_g, chain_g1, 5'd0, op(1'b0, 4), 16'hFF00, 1);
    vecs[6]  = mk("fwd_ref",   gw(op(1'b0, 6), op(1'b0, 1), op(1'b1, 0)), x3_g, 5'd1, op(1'b0, 5), 16'hAAAA, 2);
    vecs[7]  = mk("g0_const1", maj3_g, x3_g,     5'd0, op(1'b1, 0), 16'hFFFF, 1);
    vecs[8]  = mk("unrun",     maj3_g, x3_g,     5'd1, op(1'b0, 6), 16'h0000, 2);
    vecs[9]  = mk("oor_idx",   gw(op(1'b1, 31), op(1'b0, 1), op(1'b0, 2)), 18'd0, 5'd1, op(1'b0, 5), 16'hEEEE, 2);
    vecs[10] = mk("pi_inv",    maj3_g, 18'd0,    5'd0, op(1'b1, 1), 16'h5555, 1);

    rst = 1'b1; prog_we = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    prog_addr = 4'd0; prog_data = 18'd0; cfg_num_gates = 5'd0; cfg_out = 6'd0; in_data = 64'd0;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_prog_err", {31'd0, prog_err}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      prog(4'd0, vecs[i].g0);
      prog(4'd1, vecs[i].g1);
      cfg(vecs[i].ng, vecs[i].osel);
      run(1'b0, 18'd0, 1'b0, 5'd0, 6'd0, lat, data);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, "_data"}, {16'd0, data}, {16'd0, vecs[i].exp_data});
    end

    // writes landing in the same cycle as the accept
    cfg(5'd1, op(1'b0, 5));
    prog(4'd0, maj3_g);
    run(1'b1, or_g, 1'b0, 5'd0, 6'd0, lat, data);
    chk("same_cyc_prog_data", {16'd0, data}, 32'h0000EEEE);
    run(1'b0, 18'd0, 1'b1, 5'd0, op(1'b0, 3), lat, data);
    chk("same_cyc_cfg_lat", 32'(lat), 32'd1);
    chk("same_cyc_cfg_data", {16'd0, data}, 32'h0000F0F0);

    // rejected write during EVAL, then back-pressure hold
    prog(4'd0, and_g);
    prog(4'd1, chain_g1);
    cfg(5'd2, op(1'b0, 6));
    out_ready = 1'b0;
    wait_ready();
    in_valid = 1'b1; in_data = IN_VEC;
    step();
    in_valid = 1'b0;
    chk("eval_in_ready", {31'd0, in_ready}, 32'd0);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = x3_g;
    step();
    prog_we = 1'b0;
    chk("prog_err_pulse", {31'd0, prog_err}, 32'd1);
    chk("mid_eval_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("prog_err_clear", {31'd0, prog_err}, 32'd0);
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_data", {16'd0, out_data}, 32'h0000F8F8);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_stable", {15'd0, out_valid, out_data}, 32'h0001F8F8);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_ready", {31'd0, in_ready}, 32'd1);
    run(1'b0, 18'd0, 1'b0, 5'd0, 6'd0, lat, data);
    chk("unchanged_prog_lat", 32'(lat), 32'd3);
    chk("unchanged_prog_data", {16'd0, data}, 32'h0000F8F8);

    // cfg_num_gates above MAX_GATES: chain of 16 inverters
    prog(4'd0, gw(op(1'b1, 1), op(1'b0, 0), op(1'b1, 0)));
    for (int k = 1; k < 16; k++) begin
      prog(4'(k), gw(op(1'b1, 4 + k), op(1'b0, 0), op(1'b1, 0)));
    end
    cfg(5'd19, op(1'b0, 20));
    run(1'b0, 18'd0, 1'b0, 5'd0, 6'd0, lat, data);
    chk("clamp_lat", 32'(lat), 32'd17);
    chk("clamp_data", {16'd0, data}, 32'h0000AAAA);

    // reset mid-EVAL aborts the run and clears the program
    prog(4'd0, and_g);
    prog(4'd1, chain_g1);
    cfg(5'd2, op(1'b0, 6));
    wait_ready();
    in_valid = 1'b1; in_data = IN_VEC;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);
    run(1'b0, 18'd0, 1'b0, 5'd0, 6'd0, lat, data);
    chk("cleared_lat", 32'(lat), 32'd1);
    chk("cleared_data", {16'd0, data}, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
